// File: rtl/booth_mult_unit.sv
// Sequential signed DATA_W x DATA_W radix-2 Booth multiplier.
// Accepts a start in IDLE, runs DATA_W steps, then pulses mult_out with the product on HI/LO.
module booth_mult_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6    // must satisfy 2**CNT_W > DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              mult_in,
    output logic              mult_out,
    output logic              busy,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W:0]     acc_q, acc_d;
    logic [DATA_W:0]     m_q, m_d;
    logic [DATA_W-1:0]   qr_q, qr_d;
    logic                q1_q, q1_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;

    logic [DATA_W:0]     sum;
    logic [2*DATA_W+1:0] shifted;
    logic                last_step;

    assign last_step = (cnt_q == CNT_W'(DATA_W - 1));

    // One Booth step: add/subtract M, then arithmetic shift of {acc, Q, q_1}
    always_comb begin
        sum = acc_q;
        case ({qr_q[0], q1_q})
            2'b01:   sum = acc_q + m_q;
            2'b10:   sum = acc_q - m_q;
            default: sum = acc_q;
        endcase
        shifted = $signed({sum, qr_q, q1_q}) >>> 1;
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mult_in)   state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        m_d    = m_q;
        qr_d   = qr_q;
        q1_d   = q1_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (mult_in) begin
                    m_d   = {A[DATA_W-1], A};
                    qr_d  = B;
                    acc_d = '0;
                    q1_d  = 1'b0;
                    cnt_d = '0;
                end
            end
            RUN: begin
                acc_d = shifted[2*DATA_W+1:DATA_W+1];
                qr_d  = shifted[DATA_W:1];
                q1_d  = shifted[0];
                cnt_d = cnt_q + CNT_W'(1);
                // HI/LO only move here so they never expose a partial product
                if (last_step) begin
                    hi_d   = shifted[2*DATA_W:DATA_W+1];
                    lo_d   = shifted[DATA_W:1];
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            m_q    <= '0;
            qr_q   <= '0;
            q1_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            m_q    <= m_d;
            qr_q   <= qr_d;
            q1_q   <= q1_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    assign mult_out = done_q;
    assign busy     = (state_q != IDLE);
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_booth_mult_unit.sv
// Bench for booth_mult_unit: latency/product model checked every cycle plus directed literal vectors.
module tb_booth_mult_unit;

    logic        clock;
    logic        reset;
    logic [31:0] A, B;
    logic        mult_in;
    logic        mult_out, busy;
    logic [31:0] HI, LO;

    int checks   = 0;
    int failures = 0;

    booth_mult_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .A(A), .B(B), .mult_in(mult_in),
        .mult_out(mult_out), .busy(busy), .HI(HI), .LO(LO)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: a start accepted while idle finishes 32 edges later with the full signed product.
    logic               m_ok  = 1'b0;
    logic               m_act = 1'b0;
    int                 m_n   = 0;
    logic signed [63:0] m_prod, sa, sb;
    logic [31:0]        e_hi, e_lo;
    logic               e_done;

    always @(posedge clock) begin
        if (reset) begin
            m_ok = 1'b1; m_act = 1'b0; m_n = 0;
            e_hi = '0; e_lo = '0; e_done = 1'b0;
        end else if (m_ok) begin
            if (!m_act) begin
                if (mult_in) begin
                    sa = $signed(A); sb = $signed(B);
                    m_prod = sa * sb;
                    m_act = 1'b1; m_n = 0;
                end
            end else begin
                m_n++;
                if (m_n == 32) begin
                    {e_hi, e_lo} = m_prod;
                    e_done = 1'b1;
                end else if (m_n == 33) begin
                    e_done = 1'b0;
                    m_act  = 1'b0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (m_ok) begin
            chk("model_mult_out", {63'd0, mult_out}, {63'd0, e_done});
            chk("model_busy",     {63'd0, busy},     {63'd0, m_act});
            chk("model_hi",       {32'd0, HI},       {32'd0, e_hi});
            chk("model_lo",       {32'd0, LO},       {32'd0, e_lo});
        end
    end

    // Start one operation and wait for its done pulse; poke_at>0 injects a start while busy.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int poke_at);
        int  n;
        bit  got;
        @(negedge clock);
        A = a; B = b; mult_in = 1'b1;
        n = 0; got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clock);
            n++;
            if (n == 1) mult_in = 1'b0;
            if (poke_at > 0 && n == poke_at) begin
                mult_in = 1'b1; A = 32'd9; B = 32'd9;
            end
            if (poke_at > 0 && n == poke_at + 1) begin
                mult_in = 1'b0; A = $urandom; B = $urandom;
            end
            if (mult_out) got = 1'b1;
        end
        chk("latency", 64'(n), 64'd33);
        chk("hi", {32'd0, HI}, {32'd0, ehi});
        chk("lo", {32'd0, LO}, {32'd0, elo});
        chk("busy_in_done", {63'd0, busy}, 64'd1);
        @(negedge clock);
        chk("mult_out_drop", {63'd0, mult_out}, 64'd0);
        chk("busy_drop", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int n, pulses, last, extra;
        bit prev;
        reset = 1'b1; mult_in = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clock);
        chk("rst_mult_out", {63'd0, mult_out}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hi", {32'd0, HI}, 64'd0);
        chk("rst_lo", {32'd0, LO}, 64'd0);
        reset = 1'b0;

        run_op(32'd3,          32'd5,          32'h00000000, 32'h0000000F, 0);
        run_op(32'hFFFFFFF9,   32'd6,          32'hFFFFFFFF, 32'hFFFFFFD6, 0);
        run_op(32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 32'h00000001, 0);
        run_op(32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000, 0);
        run_op(32'h7FFFFFFF,   32'h80000000,   32'hC0000000, 32'h80000000, 0);
        run_op(32'h7FFFFFFF,   32'h7FFFFFFF,   32'h3FFFFFFF, 32'h00000001, 0);
        run_op(32'd0,          32'h80000000,   32'h00000000, 32'h00000000, 0);

        // Start pulsed mid-run must be dropped, not queued
        run_op(32'd3, 32'd5, 32'h00000000, 32'h0000000F, 10);
        extra = 0;
        repeat (40) begin
            @(negedge clock);
            if (mult_out) extra++;
        end
        chk("no_second_pulse", 64'(extra), 64'd0);

        // Reset in the middle of a run
        @(negedge clock);
        A = 32'd6; B = 32'd7; mult_in = 1'b1;
        @(negedge clock);
        mult_in = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_hi", {32'd0, HI}, 64'd0);
        chk("midrst_lo", {32'd0, LO}, 64'd0);
        chk("midrst_mult_out", {63'd0, mult_out}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        run_op(32'd2, 32'd2, 32'h00000000, 32'h00000004, 0);

        // mult_in held high: back-to-back operations
        @(negedge clock);
        A = 32'd2; B = 32'd3; mult_in = 1'b1;
        n = 0; pulses = 0; last = -1; prev = 1'b0;
        while (n < 200 && pulses < 3) begin
            @(negedge clock);
            n++;
            if (mult_out) begin
                pulses++;
                chk("b2b_double", {63'd0, prev}, 64'd0);
                chk("b2b_hi", {32'd0, HI}, 64'd0);
                chk("b2b_lo", {32'd0, LO}, 64'd6);
                if (last >= 0) chk("b2b_gap", 64'(n - last), 64'd34);
                last = n;
            end
            prev = mult_out;
        end
        mult_in = 1'b0;
        chk("b2b_pulses", 64'(pulses), 64'd3);
        repeat (40) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/booth_mult_unit.md
Name: booth_mult_unit

Overview:
- Sequential signed 32x32 multiplier; it is the responder side of the control unit's multiply start/stop handshake.
- The control unit raises mult_in with operands on A/B (fed from regs A and B). The unit runs radix-2 Booth iterations, then pulses mult_out with the 64-bit product on HI/LO.
- HI/LO feed the high/low registers, which the control unit loads when it sees mult_out.

Parameters:
- DATA_W, 32, operand width; product is 2*DATA_W; iteration count = DATA_W
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W

Ports:
- clock  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clock
- A  input  DATA_W  multiplicand, signed two's complement; sampled only at the start edge
- B  input  DATA_W  multiplier, signed two's complement; sampled only at the start edge
- mult_in  input  1  start request; honoured only in IDLE
- mult_out  output  1  registered one-cycle done pulse
- busy  output  1  high in RUN and DONE
- HI  output  DATA_W  product bits [2*DATA_W-1:DATA_W], registered
- LO  output  DATA_W  product bits [DATA_W-1:0], registered

Behaviour:
- Reset is synchronous and active-high and applies in any state, including mid-run.
  - state=IDLE; HI=0, LO=0, mult_out=0, busy=0.
  - Counter, accumulator, Q, q_1 and M all cleared.
- Datapath:
  - M: DATA_W+1 bits, sign-extended multiplicand.
  - acc: DATA_W+1 bits; the extra sign bit prevents overflow for M=-2^(DATA_W-1).
  - Q: DATA_W bits, the multiplier.
  - q_1: 1 bit.
- IDLE:
  - On an edge with mult_in=1: M<=sext(A), Q<=B, acc<=0, q_1<=0, cnt<=0, go to RUN.
  - On an edge with mult_in=0: stay in IDLE; HI/LO hold.
- RUN, one Booth step per edge:
  - {Q[0],q_1}=01: acc+M.
  - {Q[0],q_1}=10: acc-M.
  - 00 or 11: acc unchanged.
  - All arithmetic is DATA_W+1 bits, modular.
  - Then arithmetic-shift-right the concatenation {acc',Q,q_1} by 1 (acc MSB replicated); cnt<=cnt+1.
  - On the edge where cnt==DATA_W-1 (32nd step):
    - HI<=next {acc,Q}[2*DATA_W-1:DATA_W].
    - LO<=next Q.
    - mult_out<=1, go to DONE.
- DONE:
  - Lasts exactly one cycle with mult_out=1.
  - Next edge: mult_out<=0, go to IDLE.
- Latency:
  - Start sampled at edge E0; mult_out is high in the cycle after edge E32 and low again after E33.
  - HI/LO are valid from edge E32 and hold until the next completion or reset.
- mult_in while busy (RUN or DONE): ignored; no restart, no queueing.
  - mult_in held high continuously gives back-to-back operations; each new start is sampled in the first IDLE cycle after DONE.
- A/B changes after E0 have no effect on the running operation.
- HI/LO never show partial results: they change only at the completion edge.
- busy=1 from the cycle after E0 through the DONE cycle inclusive.

Test Plan:
- reset, then A=3, B=5, mult_in=1 for one cycle -> mult_out high exactly 32 edges after start; HI=0x00000000, LO=0x0000000F; busy drops with mult_out.
- A=-7 (0xFFFFFFF9), B=6 -> HI=0xFFFFFFFF, LO=0xFFFFFFD6; A=-1, B=-1 -> HI=0x00000000, LO=0x00000001.
- Corner operands:
  - A=0x80000000, B=0x80000000 -> HI=0x40000000, LO=0x00000000.
  - A=0x7FFFFFFF, B=0x80000000 -> HI=0xC0000000, LO=0x80000000.
- Start 3x5 and, at step 10, pulse mult_in with A=9, B=9 and change A/B -> result still HI=0, LO=15; no second mult_out follows.
- Start 6x7, assert reset at step 10 -> next cycle HI=LO=0, mult_out=0, busy=0; a new start 2x2 yields LO=4 after 32 steps.
- mult_in held high with A=2, B=3 -> mult_out pulses are separated by 34 cycles; LO=6 each time, HI=0; mult_out never high two consecutive cycles.
